// File: rtl/key_entry_buffer_if.sv
// Key entry bus: debounced key vector toward the buffer, edit-buffer state
// and per-event key information back toward the display side.
interface key_entry_buffer_if;
  logic [15:0] key_deb;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic        overflow;

  modport master (output key_deb,
                  input  digits, digit_valid, key_code, key_strobe, overflow);
  modport slave  (input  key_deb,
                  output digits, digit_valid, key_code, key_strobe, overflow);
endinterface

// File: rtl/key_entry_buffer.sv
// Key entry buffer: turns one-hot key presses into digit entry, backspace and
// clear edits on a 4-nibble register, with optional auto-repeat of a held key.
module key_entry_buffer #(
  parameter bit          REPEAT_EN  = 1'b1,
  parameter int unsigned REPEAT_DLY = 32'd25000000,
  parameter int unsigned REPEAT_PER = 32'd5000000,
  parameter logic [3:0]  BSP_CODE   = 4'd14,
  parameter logic [3:0]  CLR_CODE   = 4'd15,
  parameter bit          OVERWRITE  = 1'b0
) (
  input logic               clk,
  input logic               RSTn,
  key_entry_buffer_if.slave io_kb
);

  localparam int unsigned   HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int            CW       = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] HOLD_DLY = CW'(REPEAT_DLY - 32'd1);
  localparam logic [CW-1:0] HOLD_PER = CW'(REPEAT_PER - 32'd1);
  localparam logic [CW-1:0] HOLD_ONE = CW'(32'd1);
  localparam logic [CW-1:0] HOLD_ZERO = CW'(32'd0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_HOLD   = 2'd2,
    S_BLOCK  = 2'd3
  } state_t;

  function automatic logic f_is_onehot(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

  function automatic logic [3:0] f_encode(input logic [15:0] v);
    logic [3:0] code;
    code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        code = 4'(i);
      end
    end
    return code;
  endfunction

  function automatic logic [3:0] f_thermo(input logic [2:0] fill);
    logic [3:0] mask;
    case (fill)
      3'd0:    mask = 4'b0000;
      3'd1:    mask = 4'b0001;
      3'd2:    mask = 4'b0011;
      3'd3:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_key_q;
  logic [15:0]   r_cap, w_cap_nxt;
  logic [3:0]    r_cap_code, w_cap_code_nxt;
  logic          r_rpt, w_rpt_nxt;
  logic [CW-1:0] r_hold, w_hold_nxt;
  logic [15:0]   r_digits, w_digits_nxt;
  logic [2:0]    r_fill, w_fill_nxt;
  logic [3:0]    r_valid;
  logic [3:0]    r_code, w_code_nxt;
  logic          r_strobe, w_strobe_nxt;
  logic          r_ovf, w_ovf_nxt;

  // Next-state and edit-action decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cap_nxt      = r_cap;
    w_cap_code_nxt = r_cap_code;
    w_rpt_nxt      = r_rpt;
    w_hold_nxt     = r_hold;
    w_digits_nxt   = r_digits;
    w_fill_nxt     = r_fill;
    w_code_nxt     = r_code;
    w_strobe_nxt   = 1'b0;
    w_ovf_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_key_q == 16'h0000) begin
          w_state_nxt = S_IDLE;
        end else if (f_is_onehot(r_key_q)) begin
          w_cap_nxt      = r_key_q;
          w_cap_code_nxt = f_encode(r_key_q);
          w_rpt_nxt      = 1'b0;
          w_state_nxt    = S_ACCEPT;
        end else begin
          w_state_nxt = S_BLOCK;
        end
      end
      S_ACCEPT: begin
        w_state_nxt  = S_HOLD;
        w_strobe_nxt = 1'b1;
        w_code_nxt   = r_cap_code;
        w_hold_nxt   = r_rpt ? HOLD_PER : HOLD_DLY;
        if (r_cap_code == CLR_CODE) begin
          w_digits_nxt = 16'h0000;
          w_fill_nxt   = 3'd0;
        end else if (r_cap_code == BSP_CODE) begin
          if (r_fill != 3'd0) begin
            w_digits_nxt = {4'h0, r_digits[15:4]};
            w_fill_nxt   = r_fill - 3'd1;
          end else begin
            w_digits_nxt = r_digits;
          end
        end else if (r_fill < 3'd4) begin
          w_digits_nxt = {r_digits[11:0], r_cap_code};
          w_fill_nxt   = r_fill + 3'd1;
        end else if (OVERWRITE) begin
          w_digits_nxt = {r_digits[11:0], r_cap_code};
        end else begin
          w_ovf_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        // Counter is checked at 1 so the repeat strobe lands exactly on the period.
        if (r_key_q == 16'h0000) begin
          w_state_nxt = S_IDLE;
        end else if (r_key_q != r_cap) begin
          w_state_nxt = S_BLOCK;
        end else if (REPEAT_EN && (r_hold == HOLD_ONE)) begin
          w_state_nxt = S_ACCEPT;
          w_rpt_nxt   = 1'b1;
        end else if (r_hold != HOLD_ZERO) begin
          w_hold_nxt = r_hold - HOLD_ONE;
        end else begin
          w_hold_nxt = HOLD_ZERO;
        end
      end
      S_BLOCK: begin
        if (r_key_q == 16'h0000) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BLOCK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, key sample and registered outputs
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= S_IDLE;
      r_key_q    <= 16'h0000;
      r_cap      <= 16'h0000;
      r_cap_code <= 4'h0;
      r_rpt      <= 1'b0;
      r_hold     <= HOLD_ZERO;
      r_digits   <= 16'h0000;
      r_fill     <= 3'd0;
      r_valid    <= 4'b0000;
      r_code     <= 4'h0;
      r_strobe   <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_key_q    <= io_kb.key_deb;
      r_cap      <= w_cap_nxt;
      r_cap_code <= w_cap_code_nxt;
      r_rpt      <= w_rpt_nxt;
      r_hold     <= w_hold_nxt;
      r_digits   <= w_digits_nxt;
      r_fill     <= w_fill_nxt;
      r_valid    <= f_thermo(w_fill_nxt);
      r_code     <= w_code_nxt;
      r_strobe   <= w_strobe_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign io_kb.digits      = r_digits;
  assign io_kb.digit_valid = r_valid;
  assign io_kb.key_code    = r_code;
  assign io_kb.key_strobe  = r_strobe;
  assign io_kb.overflow    = r_ovf;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Bench for key_entry_buffer: two instances (repeat/no-overwrite and
// no-repeat/overwrite) driven by one key stream and checked against a model.
module tb_key_entry_buffer;

  localparam bit A_RE = 1'b1;
  localparam bit A_OW = 1'b0;
  localparam bit B_RE = 1'b0;
  localparam bit B_OW = 1'b1;
  localparam int DLY  = 8;
  localparam int PER  = 3;
  localparam logic [3:0] BSP = 4'd14;
  localparam logic [3:0] CLR = 4'd15;

  logic        clk;
  logic        RSTn;
  logic [15:0] key_deb;

  key_entry_buffer_if kb_a ();
  key_entry_buffer_if kb_b ();
  assign kb_a.key_deb = key_deb;
  assign kb_b.key_deb = key_deb;

  key_entry_buffer #(.REPEAT_EN(A_RE), .REPEAT_DLY(DLY), .REPEAT_PER(PER),
                     .BSP_CODE(BSP), .CLR_CODE(CLR), .OVERWRITE(A_OW))
    dut_a (.clk(clk), .RSTn(RSTn), .io_kb(kb_a));
  key_entry_buffer #(.REPEAT_EN(B_RE), .REPEAT_DLY(DLY), .REPEAT_PER(PER),
                     .BSP_CODE(BSP), .CLR_CODE(CLR), .OVERWRITE(B_OW))
    dut_b (.clk(clk), .RSTn(RSTn), .io_kb(kb_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: press epochs with absolute strobe times, digits kept as a list.
  int          e_now = 0;
  logic [15:0] mq;
  bit          m_live [2];
  bit          m_wait [2];
  logic [15:0] m_key  [2];
  int          m_t    [2];
  int          m_dig  [2][4];
  int          m_cnt  [2];
  bit          x_strobe [2];
  bit          x_ovf    [2];
  logic [3:0]  x_code   [2];

  int sc_a, sc_b, oc_a, oc_b, fs_b;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      m_live[i] = 1'b0; m_wait[i] = 1'b0; m_key[i] = 16'h0000; m_t[i] = 0;
      m_cnt[i] = 0; x_strobe[i] = 1'b0; x_ovf[i] = 1'b0; x_code[i] = 4'h0;
      for (int j = 0; j < 4; j++) m_dig[i][j] = 0;
    end
  endtask

  function automatic logic [15:0] x_digits(input int i);
    logic [15:0] r;
    r = 16'h0000;
    for (int j = 0; j < m_cnt[i]; j++)
      r = r | (16'(m_dig[i][j]) << (4 * (m_cnt[i] - 1 - j)));
    return r;
  endfunction

  function automatic logic [15:0] x_valid(input int i);
    return 16'((1 << m_cnt[i]) - 1);
  endfunction

  task automatic apply(input int i, input logic [3:0] code, input bit ow);
    if (code == CLR) begin
      m_cnt[i] = 0;
      for (int j = 0; j < 4; j++) m_dig[i][j] = 0;
    end else if (code == BSP) begin
      if (m_cnt[i] > 0) begin
        m_cnt[i]--;
        m_dig[i][m_cnt[i]] = 0;
      end
    end else if (m_cnt[i] < 4) begin
      m_dig[i][m_cnt[i]] = int'(code);
      m_cnt[i]++;
    end else if (ow) begin
      for (int j = 0; j < 3; j++) m_dig[i][j] = m_dig[i][j+1];
      m_dig[i][3] = int'(code);
    end else begin
      x_ovf[i] = 1'b1;
    end
  endtask

  // One clock edge of the model; v is what key_q held before this edge.
  task automatic model_edge();
    logic [15:0] v;
    bit re, ow, fire;
    int dt;
    v = mq;
    mq = key_deb;
    e_now++;
    for (int i = 0; i < 2; i++) begin
      re = (i == 0) ? A_RE : B_RE;
      ow = (i == 0) ? A_OW : B_OW;
      dt = e_now - m_t[i];
      fire = m_live[i] && ((dt == 0) || (re && dt >= DLY && ((dt - DLY) % PER) == 0));
      x_strobe[i] = fire;
      x_ovf[i] = 1'b0;
      if (fire) begin
        x_code[i] = 4'($clog2(m_key[i]));
        apply(i, x_code[i], ow);
      end else if (m_live[i]) begin
        if (v != m_key[i]) begin
          m_live[i] = 1'b0;
          m_wait[i] = (v != 16'h0000);
        end
      end else if (m_wait[i]) begin
        if (v == 16'h0000) m_wait[i] = 1'b0;
      end else if (v != 16'h0000) begin
        if ($countones(v) == 1) begin
          m_live[i] = 1'b1;
          m_key[i]  = v;
          m_t[i]    = e_now + 1;
        end else begin
          m_wait[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("a.digits", kb_a.digits, x_digits(0));
    chk("a.valid",  {12'h0, kb_a.digit_valid}, x_valid(0));
    chk("a.code",   {12'h0, kb_a.key_code}, {12'h0, x_code[0]});
    chk("a.strobe", {15'h0, kb_a.key_strobe}, {15'h0, x_strobe[0]});
    chk("a.ovf",    {15'h0, kb_a.overflow}, {15'h0, x_ovf[0]});
    chk("b.digits", kb_b.digits, x_digits(1));
    chk("b.valid",  {12'h0, kb_b.digit_valid}, x_valid(1));
    chk("b.code",   {12'h0, kb_b.key_code}, {12'h0, x_code[1]});
    chk("b.strobe", {15'h0, kb_b.key_strobe}, {15'h0, x_strobe[1]});
    chk("b.ovf",    {15'h0, kb_b.overflow}, {15'h0, x_ovf[1]});
  endtask

  task automatic clr_counts();
    sc_a = 0; sc_b = 0; oc_a = 0; oc_b = 0; fs_b = -1;
  endtask

  // Drive kv (at a negedge) for n cycles, stepping the model and comparing each cycle.
  task automatic step(input logic [15:0] kv, input int n);
    key_deb = kv;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (RSTn) model_edge();
      @(negedge clk);
      compare_all();
      if (kb_a.key_strobe) sc_a++;
      if (kb_b.key_strobe) sc_b++;
      if (kb_a.overflow) oc_a++;
      if (kb_b.overflow) oc_b++;
      if (kb_b.key_strobe && fs_b < 0) fs_b = k;
    end
  endtask

  task automatic press(input int k, input int hold, input int gap);
    logic [15:0] kv;
    kv = 16'h0001 << k;
    step(kv, hold);
    step(16'h0000, gap);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".digits"}, kb_a.digits | kb_b.digits, 16'h0000);
    chk({tag, ".valid"},  {8'h0, kb_a.digit_valid, kb_b.digit_valid}, 16'h0000);
    chk({tag, ".code"},   {8'h0, kb_a.key_code, kb_b.key_code}, 16'h0000);
    chk({tag, ".pulses"}, {12'h0, kb_a.key_strobe, kb_b.key_strobe, kb_a.overflow, kb_b.overflow}, 16'h0000);
  endtask

  initial begin
    RSTn = 1'b0;
    key_deb = 16'h0000;
    model_reset();
    clr_counts();
    repeat (2) @(negedge clk);
    chk_zero("rst");
    RSTn = 1'b1;
    step(16'h0000, 2);

    // Single press of key 3 held 10 cycles
    clr_counts();
    press(3, 10, 6);
    chk("lat.b", 16'(fs_b), 16'd2);
    chk("k3.b.count", 16'(sc_b), 16'd1);
    chk("k3.b.digits", kb_b.digits, 16'h0003);
    chk("k3.b.valid", {12'h0, kb_b.digit_valid}, 16'h0001);
    chk("k3.b.code", {12'h0, kb_b.key_code}, 16'h0003);
    chk("k3.a.digits", kb_a.digits, 16'h0033);
    press(15, 3, 3);

    // Digits 1..5
    clr_counts();
    for (int d = 1; d <= 5; d++) press(d, 3, 3);
    chk("fill.a.digits", kb_a.digits, 16'h1234);
    chk("fill.a.valid", {12'h0, kb_a.digit_valid}, 16'h000f);
    chk("fill.a.count", 16'(sc_a), 16'd5);
    chk("fill.a.ovf", 16'(oc_a), 16'd1);
    chk("fill.b.digits", kb_b.digits, 16'h2345);
    chk("fill.b.ovf", 16'(oc_b), 16'd0);

    // Backspace, backspace, clear, backspace on empty
    press(14, 3, 3);
    chk("bsp1.a", kb_a.digits, 16'h0123);
    press(14, 3, 3);
    chk("bsp2.a", kb_a.digits, 16'h0012);
    press(15, 3, 3);
    chk("clr.a", kb_a.digits, 16'h0000);
    chk("clr.a.valid", {12'h0, kb_a.digit_valid}, 16'h0000);
    clr_counts();
    press(14, 3, 3);
    chk("bsp0.a.count", 16'(sc_a), 16'd1);
    chk("bsp0.a.digits", kb_a.digits, 16'h0000);

    // Auto-repeat of key 7 held 20 cycles
    clr_counts();
    press(7, 20, 6);
    chk("rpt.a.count", 16'(sc_a), 16'd5);
    chk("rpt.a.ovf", 16'(oc_a), 16'd1);
    chk("rpt.a.digits", kb_a.digits, 16'h7777);
    chk("rpt.b.count", 16'(sc_b), 16'd1);
    chk("rpt.b.digits", kb_b.digits, 16'h0007);
    press(15, 3, 3);

    // Chord 2+9, release 9 only, then all, then 9 alone
    clr_counts();
    step(16'h0204, 4);
    step(16'h0004, 4);
    step(16'h0000, 4);
    chk("chord.a.count", 16'(sc_a), 16'd0);
    press(9, 3, 4);
    chk("chord.a.count2", 16'(sc_a), 16'd1);
    chk("chord.a.code", {12'h0, kb_a.key_code}, 16'h0009);
    chk("chord.a.digits", kb_a.digits, 16'h0009);

    // Reset while key 5 is held
    step(16'h0020, 6);
    chk("pre.a.digits", kb_a.digits, 16'h0095);
    RSTn = 1'b0;
    model_reset();
    #1;
    chk_zero("midrst");
    step(16'h0020, 3);
    @(negedge clk);
    RSTn = 1'b1;
    clr_counts();
    step(16'h0020, 5);
    step(16'h0000, 4);
    chk("post.a.count", 16'(sc_a), 16'd1);
    chk("post.a.digits", kb_a.digits, 16'h0005);
    chk("post.b.digits", kb_b.digits, 16'h0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_entry_buffer.md
Name: key_entry_buffer

Overview:
- Sits between key_filter (debounced 16-bit one-hot key vector) and the 4-digit display driver.
- Turns key presses into edit actions on a 4-nibble entry register: digit entry, backspace and clear. Auto-repeats a held key.
- Provides a strobe and a code for each accepted key event, plus the digit-valid mask the display uses to blank unused digits.

Parameters:
- REPEAT_EN, 1, 1 enables auto-repeat of a held key; 0 gives one event per press.
- REPEAT_DLY, 25000000, cycles from the first event to the first repeat (0.5 s at 50 MHz); must be at least 2.
- REPEAT_PER, 5000000, cycles between later repeats (0.1 s); must be at least 2.
- BSP_CODE, 14, key code treated as backspace.
- CLR_CODE, 15, key code treated as clear.
- OVERWRITE, 0, 1 = a digit entered into a full buffer drops the oldest digit; 0 = the digit is ignored and overflow pulses.

Ports:
- clk  in  1  system clock (50 MHz)
- RSTn  in  1  asynchronous active-low reset
- key_deb  in  16  debounced key vector, bit i high = key i held, synchronous to clk
- digits  out  16  entry register; [3:0] newest digit, [15:12] oldest
- digit_valid  out  4  thermometer mask of filled digits; bit0 = newest position
- key_code  out  4  code of the last accepted event
- key_strobe  out  1  one-cycle pulse per accepted event, including repeats
- overflow  out  1  one-cycle pulse when a digit is rejected because the buffer is full

Behaviour:
- Reset (async assert, sync release): the following all clear to 0:
  - digits, digit_valid, key_code, key_strobe, overflow
  - fill count and the internal key register key_q
  - FSM goes to IDLE.
- key_q <= key_deb every cycle. Code of a one-hot value = index of its set bit.
- FSM states: IDLE, ACCEPT, HOLD, BLOCK.
  - IDLE: key_q == 0 -> stay. key_q exactly one-hot -> capture it and its code, go to ACCEPT. More than one bit set -> BLOCK.
  - ACCEPT (one cycle): perform the action. Registered outputs update on the next edge. Load the hold counter with REPEAT_DLY-1 on the first event, or REPEAT_PER-1 on a repeat. Go to HOLD.
  - HOLD: key_q == 0 -> IDLE. key_q != captured value -> BLOCK. Otherwise decrement the counter. When the counter reaches 0 and REPEAT_EN == 1 -> ACCEPT (repeat).
  - BLOCK: no actions. Leave to IDLE only when key_q == 0.
- Latency: key_deb first sampled one-hot at edge N -> ACCEPT at N+1 -> digits, key_code, key_strobe and overflow valid after edge N+2.
- Repeat timing: the first strobe occurs at cycle T. Later strobes occur at T+REPEAT_DLY, then every REPEAT_PER cycles while the key is held alone.
- Actions, with fill count cnt in the range 0..4:
  - Digit key (code not BSP_CODE and not CLR_CODE):
    - cnt < 4: digits <= {digits[11:0], code}; cnt++.
    - cnt == 4, OVERWRITE = 1: same shift, cnt stays 4.
    - cnt == 4, OVERWRITE = 0: digits unchanged; overflow = 1 for one cycle.
  - BSP_CODE:
    - cnt > 0: digits <= {4'h0, digits[15:4]}; cnt--.
    - cnt == 0: no-op.
  - CLR_CODE: digits <= 0; cnt <= 0.
- key_strobe and key_code are produced for every accepted event, including no-ops and rejected digits.
- digit_valid follows cnt: 0 -> 0000, 1 -> 0001, 2 -> 0011, 3 -> 0111, 4 -> 1111.
- Key release and a new key in the same cycle (captured bit drops while another rises) is not zero, so the FSM goes to BLOCK. It must return to 0 before the new key is accepted.
- Reset during HOLD or BLOCK: the FSM goes to IDLE. A key still held after release is seen as a new press and accepted once.
- All outputs are registered.

Test Plan:
- Reset, then press key 3 alone for 10 cycles and release (REPEAT_EN=0) -> one key_strobe, key_code=3, digits=0x0003, digit_valid=0001, strobe 2 cycles after key_q sees the key.
- Press 1, 2, 3, 4, 5 in turn (OVERWRITE=0) -> digits=0x1234, digit_valid=1111. The fifth press gives key_strobe plus overflow. Repeat with OVERWRITE=1 -> digits=0x2345, no overflow.
- From 0x1234, press E twice, then F -> digits 0x0123, 0x0012, then 0x0000, digit_valid=0000. A further E -> strobe, no change.
- REPEAT_DLY=8, REPEAT_PER=3, hold key 7 for 20 cycles -> strobes at T, T+8, T+11, T+14, T+17; digits fill to 0x7777, and the last repeat drives overflow.
- Press 2 and 9 together, then release 9 only -> no strobe. After both are released, press 9 -> one strobe, key_code=9.
- Hold key 5 in HOLD, assert RSTn=0 for 3 cycles -> all outputs 0 immediately. After release with key 5 still held -> one strobe, digits=0x0005.
